// File: rtl/adder_pkg.sv
// Shared constants and FSM state encoding for the bit-serial adder family.
package adder_pkg;

  localparam int ADDER_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Combinational full adder assembled from two half-adder cells and an OR.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  logic s0, c0, c1;

  half_adder u_ha0 (.a(a),  .b(b),   .sum(s0),  .carry(c0));
  half_adder u_ha1 (.a(s0), .b(cin), .sum(sum), .carry(c1));

  assign carry = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Single-bit half-adder cell: the base arithmetic primitive of the datapath library.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder, one bit per clock LSB first, valid/ready on both sides.
// Optional subtract mode (sub port) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
  import adder_pkg::*;
#(
  parameter int W = ADDER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         carry
`ifdef SERIAL_ADDER_SUB_EN
  ,
  input  logic         sub
`endif
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready/valid here decode from state alone, never from the peer.
  localparam int            CW   = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         state, state_nxt;
  logic [W-1:0]   a_sh, b_sh, sum_sh, sum_sh_nxt;
  logic [W-1:0]   b_load;
  logic           c_q, c_load;
  logic [CW-1:0]  cnt;
  logic           fa_s, fa_co;
  logic           accept, last_bit;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (c_q),
    .sum  (fa_s),
    .carry(fa_co)
  );

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: a + ~b + 1, so carry=1 means no borrow.
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid & in_ready;
  assign last_bit  = (state == ST_RUN) && (cnt == LAST);

  // New bit enters at the MSB; written as shift/OR so W=1 needs no empty slice.
  assign sum_sh_nxt = (sum_sh >> 1) | (W'(fa_s) << (W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
      ST_RUN:  if (last_bit)  state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      c_q    <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      carry  <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b_load;
      c_q  <= c_load;
      cnt  <= '0;
    end else if (state == ST_RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= sum_sh_nxt;
      c_q    <= fa_co;
      cnt    <= cnt + 1'b1;
      if (last_bit) begin
        sum   <= sum_sh_nxt;
        carry <= fa_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: W=8, W=2 and W=1 instances against an arithmetic reference.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] iv = 3'b000;
  logic [7:0] a_in = '0, b_in = '0;
  logic       cin_in = 1'b0, sub_in = 1'b0, out_ready = 1'b0;

  logic       rdy8, rdy2, rdy1, ov8, ov2, ov1, c8, c2, c1;
  logic [7:0] sum8;
  logic [1:0] sum2;
  logic [0:0] sum1;

  int         sel = 0;
  logic       sel_ready, sel_valid, sel_carry;
  logic [7:0] sel_sum;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.W(8)) u_add8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy8),
    .a(a_in), .b(b_in), .cin(cin_in), .out_valid(ov8), .out_ready(out_ready),
    .sum(sum8), .carry(c8)
`ifdef SERIAL_ADDER_SUB_EN
    , .sub(sub_in)
`endif
  );

  serial_adder #(.W(2)) u_add2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy2),
    .a(a_in[1:0]), .b(b_in[1:0]), .cin(cin_in), .out_valid(ov2), .out_ready(out_ready),
    .sum(sum2), .carry(c2)
`ifdef SERIAL_ADDER_SUB_EN
    , .sub(sub_in)
`endif
  );

  serial_adder #(.W(1)) u_add1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy1),
    .a(a_in[0:0]), .b(b_in[0:0]), .cin(cin_in), .out_valid(ov1), .out_ready(out_ready),
    .sum(sum1), .carry(c1)
`ifdef SERIAL_ADDER_SUB_EN
    , .sub(sub_in)
`endif
  );

  always_comb begin
    sel_ready = 1'b0;
    sel_valid = 1'b0;
    sel_sum   = '0;
    sel_carry = 1'b0;
    case (sel)
      0: begin sel_ready = rdy8; sel_valid = ov8; sel_sum = sum8;          sel_carry = c8; end
      1: begin sel_ready = rdy2; sel_valid = ov2; sel_sum = {6'b0, sum2};  sel_carry = c2; end
      default: begin sel_ready = rdy1; sel_valid = ov1; sel_sum = {7'b0, sum1}; sel_carry = c1; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands, reduced to w bits.
  function automatic void ref_model(input int w, input int av, input int bv, input int ci,
                                    input int sb, output int es, output int ec);
    int mask, total;
    mask = (1 << w) - 1;
    av   = av & mask;
    bv   = bv & mask;
    if (sb != 0) begin
      es = (av - bv) & mask;
      ec = (av >= bv) ? 1 : 0;
    end else begin
      total = av + bv + ci;
      es    = total & mask;
      ec    = (total >> w) & 1;
    end
  endfunction

  task automatic start_op(input int s, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input logic sb);
    int n;
    sel = s;
    @(negedge clk);
    a_in = av; b_in = bv; cin_in = ci; sub_in = sb;
    iv[s] = 1'b1;
    n = 0;
    while (!sel_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {31'b0, sel_ready}, 32'd1);
    @(posedge clk);
    #1;
    iv[s] = 1'b0;
    // Operands must have been captured at the accept edge; scramble them now.
    a_in = 8'($urandom); b_in = 8'($urandom);
    cin_in = 1'($urandom); sub_in = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!sel_valid && lat < 100);
    check("done_valid", {31'b0, sel_valid}, 32'd1);
  endtask

  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic do_op(input string tag, input int s, input int w, input logic [7:0] av,
                       input logic [7:0] bv, input logic ci, input logic sb, output int lat);
    int es, ec;
    ref_model(w, av, bv, ci, sb, es, ec);
    start_op(s, av, bv, ci, sb);
    wait_done(lat);
    check({tag, "_sum"}, {24'b0, sel_sum}, es);
    check({tag, "_carry"}, {31'b0, sel_carry}, ec);
    finish_op();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, es, ec;
    logic [7:0] ra, rb;
    logic rc, rs;
    int bad;

    // Reset held three cycles
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'b0, rdy8}, 32'd1);
    check("rst_out_valid", {31'b0, ov8}, 32'd0);
    check("rst_sum", {24'b0, sum8}, 32'd0);
    check("rst_carry", {31'b0, c8}, 32'd0);
    check("rst_in_ready_w1", {31'b0, rdy1}, 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases
    do_op("0f_01", 0, 8, 8'h0F, 8'h01, 1'b0, 1'b0, lat);
    check("latency_w8", lat, 32'd8);
    do_op("ff_01", 0, 8, 8'hFF, 8'h01, 1'b0, 1'b0, lat);
    do_op("ff_ff_1", 0, 8, 8'hFF, 8'hFF, 1'b1, 1'b0, lat);

    // Backpressure in DONE with a stray in_valid pulse
    ref_model(8, 8'h3C, 8'h5A, 1, 0, es, ec);
    start_op(0, 8'h3C, 8'h5A, 1'b1, 1'b0);
    wait_done(lat);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        a_in = 8'hAA; b_in = 8'h55; iv[0] = 1'b1;
      end else begin
        iv[0] = 1'b0;
      end
      check("bp_sum", {24'b0, sum8}, es);
      check("bp_carry", {31'b0, c8}, ec);
      check("bp_in_ready", {31'b0, rdy8}, 32'd0);
      check("bp_out_valid", {31'b0, ov8}, 32'd1);
      @(negedge clk);
    end
    iv[0] = 1'b0;
    finish_op();
    @(negedge clk);
    check("bp_ready_back", {31'b0, rdy8}, 32'd1);
    check("bp_sum_kept", {24'b0, sum8}, es);
    bad = 0;
    repeat (12) begin
      if (ov8 !== 1'b0) bad++;
      @(negedge clk);
    end
    check("bp_no_extra_result", bad, 32'd0);

    // Reset asserted mid-operation aborts it
    start_op(0, 8'h12, 8'h34, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_sum_cleared", {24'b0, sum8}, 32'd0);
    rst_n = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov8 !== 1'b0 || rdy8 !== 1'b1) bad++;
    end
    check("abort_no_result", bad, 32'd0);

    // W=2 exhaustive
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        for (int c = 0; c < 2; c++) begin
          do_op("w2", 1, 2, 8'(x), 8'(y), 1'(c), 1'b0, lat);
          check("w2_latency", lat, 32'd2);
        end

    // W=1 smoke case
    do_op("w1_111", 2, 1, 8'h01, 8'h01, 1'b1, 1'b0, lat);
    check("w1_latency", lat, 32'd1);

`ifdef SERIAL_ADDER_SUB_EN
    do_op("sub_05_07", 0, 8, 8'h05, 8'h07, 1'b0, 1'b1, lat);
    do_op("sub_07_05", 0, 8, 8'h07, 8'h05, 1'b1, 1'b1, lat);
`endif

    // Random W=8 operations, operands scrambled after accept
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      do_op("rand", 0, 8, ra, rb, rc, rs, lat);
      check("rand_latency", lat, 32'd8);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
